dram_mem: RTL and testbench

DRAM_MEM -- requirements
Module: dram_mem

---
 rtl/dram_pkg.sv | 17 +
 rtl/dram_mem_core.sv | 34 +++
 rtl/dram_mem.sv | 94 +++++++++
 tb/tb_dram_mem.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared widths, data word type and read-source encoding for dram_mem
package dram_pkg;

  localparam int DRAM_ADDR_W = 20;
  localparam int DRAM_DATA_W = 8;
  localparam int DRAM_DEPTH  = 2**DRAM_ADDR_W;

  typedef logic [DRAM_DATA_W-1:0] dram_word_t;

  // Where the registered read result comes from on the cycle after a read
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_BYP  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/dram_mem_core.sv
// rtl/dram_mem_core.sv - raw DEPTH x DATA_W array, synchronous write and read, no reset
module dram_mem_core
  import dram_pkg::*;
#(
  parameter int ADDR_W = DRAM_ADDR_W,
  parameter int DATA_W = DRAM_DATA_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // Power-up contents are zero; reset never touches the array
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_q;

  // Read returns the pre-write value; write-first is resolved by the caller
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/dram_mem.sv
// rtl/dram_mem.sv - simple dual-port memory with write-first bypass, range masking and async-reset read outputs
module dram_mem
  import dram_pkg::*;
#(
  parameter int ADDR_W = DRAM_ADDR_W,
  parameter int DATA_W = DRAM_DATA_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              raddr_ok;
  logic              waddr_ok;
  logic              core_wr_en;
  logic              core_rd_en;
  logic [DATA_W-1:0] core_rd_data;

  rd_src_e           src_d, src_q;
  logic [DATA_W-1:0] byp_d, byp_q;
  logic              rvalid_d, rvalid_q;

  assign raddr_ok = ({1'b0, raddr} < DEPTH_L);
  assign waddr_ok = ({1'b0, waddr} < DEPTH_L);

  // Accesses presented during reset must not reach the array
  assign core_wr_en = wen & rst_n & waddr_ok;
  assign core_rd_en = ren & rst_n & raddr_ok;

  dram_mem_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk       (clk),
    .wr_en_i   (core_wr_en),
    .wr_addr_i (waddr),
    .wr_data_i (wdata),
    .rd_en_i   (core_rd_en),
    .rd_addr_i (raddr),
    .rd_data_o (core_rd_data)
  );

  always_comb begin
    src_d    = src_q;
    byp_d    = byp_q;
    rvalid_d = 1'b0;
    if (ren) begin
      rvalid_d = 1'b1;
      if (!raddr_ok) begin
        src_d = SRC_ZERO;
      end else if (wen && (waddr == raddr)) begin
        src_d = SRC_BYP;
        byp_d = wdata;
      end else begin
        src_d = SRC_MEM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= SRC_ZERO;
      byp_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      src_q    <= src_d;
      byp_q    <= byp_d;
      rvalid_q <= rvalid_d;
    end
  end

  // The core read register is only loaded on accepted reads, so holding src_q holds rdata
  always_comb begin
    rdata = '0;
    case (src_q)
      SRC_MEM: rdata = core_rd_data;
      SRC_BYP: rdata = byp_q;
      default: rdata = '0;
    endcase
  end

  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_dram_mem.sv
// tb/tb_dram_mem.sv - self-checking bench for dram_mem with a map-based reference model
module tb_dram_mem;
  import dram_pkg::*;

  localparam int AW     = 20;
  localparam int DW     = 8;
  localparam int SAW    = 4;
  localparam int SDEPTH = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ren = 1'b0, wen = 1'b0;
  logic [AW-1:0] raddr = '0, waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;

  logic s_ren = 1'b0, s_wen = 1'b0;
  logic [SAW-1:0] s_raddr = '0, s_waddr = '0;
  logic [DW-1:0] s_wdata = '0;
  logic [DW-1:0] s_rdata;
  logic          s_rvalid;

  int errors = 0;
  int checks = 0;

  dram_word_t model [int];
  dram_word_t s_model [int];
  dram_word_t exp_rdata = '0, s_exp_rdata = '0;
  logic       exp_rvalid = 1'b0, s_exp_rvalid = 1'b0;

  dram_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .raddr(raddr),
    .waddr(waddr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid)
  );

  dram_mem #(.ADDR_W(SAW), .DATA_W(DW), .DEPTH(SDEPTH)) dut_s (
    .clk(clk), .rst_n(rst_n), .ren(s_ren), .wen(s_wen), .raddr(s_raddr),
    .waddr(s_waddr), .wdata(s_wdata), .rdata(s_rdata), .rvalid(s_rvalid)
  );

  always #5 clk = ~clk;

  function automatic dram_word_t peek(input int a);
    return model.exists(a) ? model[a] : 8'h00;
  endfunction

  function automatic dram_word_t s_peek(input int a);
    return s_model.exists(a) ? s_model[a] : 8'h00;
  endfunction

  // One rising edge: update the reference from the pre-edge inputs, then settle
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (ren) begin
        exp_rvalid = 1'b1;
        exp_rdata  = (wen && waddr == raddr) ? wdata : peek(int'(raddr));
      end else begin
        exp_rvalid = 1'b0;
      end
      if (wen) model[int'(waddr)] = wdata;
      if (s_ren) begin
        s_exp_rvalid = 1'b1;
        if (int'(s_raddr) >= SDEPTH)                 s_exp_rdata = 8'h00;
        else if (s_wen && s_waddr == s_raddr)        s_exp_rdata = s_wdata;
        else                                         s_exp_rdata = s_peek(int'(s_raddr));
      end else begin
        s_exp_rvalid = 1'b0;
      end
      if (s_wen && int'(s_waddr) < SDEPTH) s_model[int'(s_waddr)] = s_wdata;
    end else begin
      exp_rdata = '0; exp_rvalid = 1'b0; s_exp_rdata = '0; s_exp_rvalid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_async_rdata: got %h want 00", rdata); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_async_rvalid: got %b want 0", rvalid); end
    tick(); tick();
    checks++; if (s_rvalid !== 1'b0 || s_rdata !== 8'h00) begin errors++; $display("FAIL reset_small: got %b/%h want 0/00", s_rvalid, s_rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    ren = 0; wen = 0; waddr = '0; wdata = 8'hFF;
    tick();
    checks++; if (rdata !== 8'h00 || rvalid !== 1'b0) begin errors++; $display("FAIL idle_out: got %h/%b want 00/0", rdata, rvalid); end
    ren = 1; raddr = '0;
    tick();
    ren = 0;
    checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++; $display("FAIL idle_mem0: got %h/%b want 00/1", rdata, rvalid); end
  endtask

  task automatic test_write_read();
    wen = 1; waddr = '0; wdata = 8'hFF;
    tick();
    wen = 0; ren = 1; raddr = '0;
    tick();
    checks++; if (rdata !== 8'hFF || rvalid !== 1'b1) begin errors++; $display("FAIL wr_rd: got %h/%b want ff/1", rdata, rvalid); end
    ren = 0;
    tick();
    checks++; if (rdata !== 8'hFF || rvalid !== 1'b0) begin errors++; $display("FAIL wr_rd_hold: got %h/%b want ff/0", rdata, rvalid); end
  endtask

  task automatic test_reset_mid();
    ren = 1; raddr = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rdata !== 8'h00 || rvalid !== 1'b0) begin errors++; $display("FAIL reset_mid: got %h/%b want 00/0", rdata, rvalid); end
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_mid_read_ignored: got %b want 0", rvalid); end
    ren = 0; rst_n = 1'b1;
    tick();
    ren = 1; raddr = '0;
    tick();
    ren = 0;
    checks++; if (rdata !== 8'hFF || rvalid !== 1'b1) begin errors++; $display("FAIL reset_retained: got %h/%b want ff/1", rdata, rvalid); end
  endtask

  task automatic test_same_addr();
    ren = 1; wen = 1; raddr = 20'h00010; waddr = 20'h00010; wdata = 8'hA5;
    tick();
    wen = 0;
    checks++; if (rdata !== 8'hA5 || rvalid !== 1'b1) begin errors++; $display("FAIL same_addr_bypass: got %h/%b want a5/1", rdata, rvalid); end
    tick();
    ren = 0;
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL same_addr_stored: got %h want a5", rdata); end
  endtask

  task automatic test_top_addr();
    wen = 1; waddr = 20'hFFFFF; wdata = 8'h3C;
    tick();
    wen = 0; ren = 1; raddr = 20'hFFFFF;
    tick();
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL top_addr: got %h want 3c", rdata); end
    raddr = 20'hFFFFE;
    tick();
    ren = 0;
    checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++; $display("FAIL top_minus1: got %h/%b want 00/1", rdata, rvalid); end
  endtask

  task automatic test_write_during_reset();
    rst_n = 1'b0;
    wen = 1; waddr = 20'd5; wdata = 8'h77;
    s_wen = 1; s_waddr = 4'd5; s_wdata = 8'h77;
    tick(); tick();
    wen = 0; s_wen = 0;
    #2 rst_n = 1'b1;
    tick();
    ren = 1; raddr = 20'd5; s_ren = 1; s_raddr = 4'd5;
    tick();
    ren = 0; s_ren = 0;
    checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++; $display("FAIL wr_in_reset: got %h/%b want 00/1", rdata, rvalid); end
    checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL wr_in_reset_small: got %h want 00", s_rdata); end
  endtask

  task automatic test_out_of_range();
    s_wen = 1; s_waddr = 4'd3; s_wdata = 8'h11;
    tick();
    s_waddr = 4'd12; s_wdata = 8'h99;
    tick();
    s_wen = 0; s_ren = 1; s_raddr = 4'd12;
    tick();
    checks++; if (s_rdata !== 8'h00 || s_rvalid !== 1'b1) begin errors++; $display("FAIL oor_read: got %h/%b want 00/1", s_rdata, s_rvalid); end
    s_raddr = 4'd3;
    tick();
    checks++; if (s_rdata !== 8'h11) begin errors++; $display("FAIL in_range_read: got %h want 11", s_rdata); end
    s_wen = 1; s_waddr = 4'd13; s_raddr = 4'd13; s_wdata = 8'h5A;
    tick();
    s_wen = 0; s_ren = 0;
    checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL oor_bypass: got %h want 00", s_rdata); end
    s_ren = 1; s_raddr = 4'd9;
    tick();
    s_ren = 0;
    checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL last_in_range: got %h want 00", s_rdata); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      wen = 1; waddr = 20'h00200 + 20'(i); wdata = 8'($urandom);
      ren = (i > 0); raddr = 20'h00200 + 20'(i) - 20'd1;
      tick();
      if (i > 0) begin
        checks++;
        if (rdata !== exp_rdata || rvalid !== 1'b1) begin
          errors++; $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, rdata, rvalid, exp_rdata);
        end
      end
    end
    wen = 0; ren = 0;
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    base = 20'(32'hABC00 + $urandom_range(0, 255));
    for (int i = 0; i < 400; i++) begin
      ren = 1'($urandom); wen = 1'($urandom);
      raddr = base + 20'($urandom_range(0, 7));
      waddr = base + 20'($urandom_range(0, 7));
      wdata = 8'($urandom);
      s_ren = 1'($urandom); s_wen = 1'($urandom);
      s_raddr = 4'($urandom); s_waddr = 4'($urandom); s_wdata = 8'($urandom);
      tick();
      checks++;
      if (rdata !== exp_rdata || rvalid !== exp_rvalid) begin
        errors++; $display("FAIL rand[%0d]: got %h/%b want %h/%b", i, rdata, rvalid, exp_rdata, exp_rvalid);
      end
      checks++;
      if (s_rdata !== s_exp_rdata || s_rvalid !== s_exp_rvalid) begin
        errors++; $display("FAIL rand_small[%0d]: got %h/%b want %h/%b", i, s_rdata, s_rvalid, s_exp_rdata, s_exp_rvalid);
      end
    end
    ren = 0; wen = 0; s_ren = 0; s_wen = 0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write_read();
    test_reset_mid();
    test_same_addr();
    test_top_addr();
    test_write_during_reset();
    test_out_of_range();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
